multicycle_controller: RTL

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/riscv_pkg.sv | 63 ++++++
 rtl/opcode_decoder.sv | 30 +++
 rtl/multicycle_controller.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RISC-V controller.
// Holds opcode constants, FSM state encodings, the instruction-class
// enumeration and the datapath mux / ALU operation encodings.
package riscv_pkg;

    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned STATE_W  = 3;
    localparam int unsigned WAIT_W   = 8;

    // Supported opcodes
    localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_IALU   = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;

    // FSM state encodings; 5 and 6 are unused and recover to TRAP
    typedef enum logic [STATE_W-1:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd7
    } state_e;

    // Instruction class latched in DECODE
    typedef enum logic [2:0] {
        CL_R    = 3'd0,
        CL_IALU = 3'd1,
        CL_LD   = 3'd2,
        CL_SD   = 3'd3,
        CL_BEQ  = 3'd4,
        CL_JAL  = 3'd5,
        CL_ILL  = 3'd6
    } iclass_e;

    // ALU operation select
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU operand A select
    localparam logic ALUSRCA_RS1 = 1'b0;
    localparam logic ALUSRCA_PC  = 1'b1;

    // ALU operand B select
    localparam logic [1:0] ALUSRC_RS2  = 2'd0;
    localparam logic [1:0] ALUSRC_IMM  = 2'd1;
    localparam logic [1:0] ALUSRC_FOUR = 2'd2;

    // Register write-back source select
    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MEM = 2'd1;
    localparam logic [1:0] M2R_PC4 = 2'd2;

    // States that wait on memoryReady and run the timeout counter
    function automatic logic is_wait_state(input state_e s);
        return (s == ST_FETCH) || (s == ST_MEMORY);
    endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode-to-instruction-class decoder.
// Ports:
//   i_opcode : 7-bit opcode field from the instruction register
//   o_class  : decoded instruction class (CL_ILL for anything unsupported)
// ENABLE_JAL / ENABLE_IMM (0 or 1) make JAL / I-type ALU illegal when 0.
module opcode_decoder
    import riscv_pkg::*;
#(
    parameter int unsigned ENABLE_JAL = 1,
    parameter int unsigned ENABLE_IMM = 1
) (
    input  logic [OPCODE_W-1:0] i_opcode,
    output iclass_e             o_class
);

    // Any opcode not matched below, or a disabled one, decodes as illegal
    always_comb begin
        o_class = CL_ILL;
        case (i_opcode)
            OP_RTYPE:  o_class = CL_R;
            OP_IALU:   if (ENABLE_IMM != 0) o_class = CL_IALU;
            OP_LOAD:   o_class = CL_LD;
            OP_STORE:  o_class = CL_SD;
            OP_BRANCH: o_class = CL_BEQ;
            OP_JAL:    if (ENABLE_JAL != 0) o_class = CL_JAL;
            default:   o_class = CL_ILL;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM (FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/TRAP).
// Ports:
//   clock, reset       : rising-edge clock, synchronous active-high reset
//   opcode             : instruction opcode, latched as a class in DECODE
//   memoryReady        : memory completed the current access this cycle
//   instrRead, irWrite, pcWrite, branch, jump,
//   memoryRead, memoryWrite, regWrite : datapath strobes (0 while reset=1)
//   ALUSrcA, ALUSrc, ALUOp, memoryToRegister : datapath mux / ALU selects
//   illegalInstr, busError : sticky error flags, cleared only by reset
//   state              : current state encoding for debug
module multicycle_controller
    import riscv_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned ENABLE_JAL  = 1,
    parameter int unsigned ENABLE_IMM  = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                memoryReady,
    output logic                instrRead,
    output logic                irWrite,
    output logic                pcWrite,
    output logic                branch,
    output logic                jump,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrc,
    output logic [1:0]          ALUOp,
    output logic                memoryRead,
    output logic                memoryWrite,
    output logic [1:0]          memoryToRegister,
    output logic                regWrite,
    output logic                illegalInstr,
    output logic                busError,
    output logic [STATE_W-1:0]  state
);

    localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);

    state_e              r_state;
    iclass_e             r_class;
    logic [WAIT_W-1:0]   r_wait;
    logic                r_illegal;
    logic                r_bus_error;

    iclass_e             w_dec_class;
    logic                w_timeout;

    logic                w_instr_read;
    logic                w_ir_write;
    logic                w_pc_write;
    logic                w_branch;
    logic                w_jump;
    logic                w_mem_read;
    logic                w_mem_write;
    logic                w_reg_write;
    logic                w_alu_src_a;
    logic [1:0]          w_alu_src;
    logic [1:0]          w_alu_op;
    logic [1:0]          w_mem_to_reg;

    opcode_decoder #(
        .ENABLE_JAL (ENABLE_JAL),
        .ENABLE_IMM (ENABLE_IMM)
    ) u_opcode_decoder (
        .i_opcode (opcode),
        .o_class  (w_dec_class)
    );

    // Timeout fires only in the cycle the counter already holds MEM_TIMEOUT
    // and memory is still not ready; ready in that same cycle is a success.
    assign w_timeout = is_wait_state(r_state) && !memoryReady
                       && (r_wait >= TIMEOUT_CNT);

    // State, class, wait counter and sticky flags
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_FETCH;
            r_class     <= CL_ILL;
            r_wait      <= '0;
            r_illegal   <= 1'b0;
            r_bus_error <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (memoryReady) begin
                        r_state <= ST_DECODE;
                        r_wait  <= '0;
                    end else if (w_timeout) begin
                        r_state     <= ST_TRAP;
                        r_bus_error <= 1'b1;
                        r_wait      <= '0;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                ST_DECODE: begin
                    r_class <= w_dec_class;
                    r_wait  <= '0;
                    if (w_dec_class == CL_ILL) begin
                        r_state   <= ST_TRAP;
                        r_illegal <= 1'b1;
                    end else begin
                        r_state <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    // Counter is zeroed here so MEMORY is always entered at 0
                    r_wait <= '0;
                    case (r_class)
                        CL_R, CL_IALU, CL_JAL: r_state <= ST_WRITEBACK;
                        CL_LD, CL_SD:          r_state <= ST_MEMORY;
                        CL_BEQ:                r_state <= ST_FETCH;
                        default:               r_state <= ST_TRAP;
                    endcase
                end
                ST_MEMORY: begin
                    if (memoryReady) begin
                        r_state <= (r_class == CL_LD) ? ST_WRITEBACK : ST_FETCH;
                        r_wait  <= '0;
                    end else if (w_timeout) begin
                        r_state     <= ST_TRAP;
                        r_bus_error <= 1'b1;
                        r_wait      <= '0;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                ST_WRITEBACK: begin
                    r_state <= ST_FETCH;
                    r_wait  <= '0;
                end
                ST_TRAP: begin
                    // Absorbing: flags and class hold until reset
                    r_state <= ST_TRAP;
                end
                default: begin
                    // Unused encodings recover to TRAP without touching flags
                    r_state <= ST_TRAP;
                end
            endcase
        end
    end

    // Output decode from state and class; only the FETCH load strobes are
    // qualified by memoryReady so the IR and PC update on the completing beat.
    always_comb begin
        w_instr_read = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_jump       = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_src_a  = ALUSRCA_RS1;
        w_alu_src    = ALUSRC_RS2;
        w_alu_op     = ALUOP_ADD;
        w_mem_to_reg = M2R_ALU;
        case (r_state)
            ST_FETCH: begin
                w_instr_read = 1'b1;
                w_alu_src    = ALUSRC_FOUR;
                if (memoryReady) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                end
            end
            ST_EXECUTE: begin
                case (r_class)
                    CL_R: begin
                        w_alu_src = ALUSRC_RS2;
                        w_alu_op  = ALUOP_FUNCT;
                    end
                    CL_IALU: begin
                        w_alu_src = ALUSRC_IMM;
                        w_alu_op  = ALUOP_FUNCT;
                    end
                    CL_LD, CL_SD: begin
                        w_alu_src = ALUSRC_IMM;
                        w_alu_op  = ALUOP_ADD;
                    end
                    CL_BEQ: begin
                        w_branch  = 1'b1;
                        w_alu_src = ALUSRC_RS2;
                        w_alu_op  = ALUOP_SUB;
                    end
                    CL_JAL: begin
                        w_pc_write  = 1'b1;
                        w_jump      = 1'b1;
                        w_alu_src_a = ALUSRCA_PC;
                        w_alu_src   = ALUSRC_IMM;
                    end
                    default: begin
                    end
                endcase
            end
            ST_MEMORY: begin
                w_mem_read  = (r_class == CL_LD);
                w_mem_write = (r_class == CL_SD);
            end
            ST_WRITEBACK: begin
                w_reg_write = 1'b1;
                if (r_class == CL_LD) begin
                    w_mem_to_reg = M2R_MEM;
                end else if (r_class == CL_JAL) begin
                    w_mem_to_reg = M2R_PC4;
                end else begin
                    w_mem_to_reg = M2R_ALU;
                end
            end
            default: begin
            end
        endcase
    end

    // Strobes are forced low while reset is asserted
    assign instrRead        = w_instr_read & ~reset;
    assign irWrite          = w_ir_write   & ~reset;
    assign pcWrite          = w_pc_write   & ~reset;
    assign branch           = w_branch     & ~reset;
    assign jump             = w_jump       & ~reset;
    assign memoryRead       = w_mem_read   & ~reset;
    assign memoryWrite      = w_mem_write  & ~reset;
    assign regWrite         = w_reg_write  & ~reset;
    assign ALUSrcA          = w_alu_src_a;
    assign ALUSrc           = w_alu_src;
    assign ALUOp            = w_alu_op;
    assign memoryToRegister = w_mem_to_reg;
    assign illegalInstr     = r_illegal;
    assign busError         = r_bus_error;
    assign state            = r_state;

endmodule
